hex_digit_scanner: RTL and testbench
====================================

Name: hex_digit_scanner

Overview:
- Time-multiplexed driver for an N-digit common-anode 7-segment display.
- Sits directly upstream of the seg7 hex decoder.
- Latches a multi-digit hex value and presents one nibble at a time on digit_out, which feeds seg7.in.
- Drives the matching active-low digit enable, with optional leading-zero blanking and tear-free frame-aligned updates.

Parameters:
- NUM_DIGITS, 4, number of display digits (2..8).
- REFRESH_DIV, 50000, clk cycles each digit stays active (>=2).
- CNT_W, 16, prescaler width; must satisfy 2**CNT_W >= REFRESH_DIV.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- value_in  input  4*NUM_DIGITS  hex value to display; digit i = value_in[4i+3:4i].
- load  input  1  one-cycle strobe capturing value_in.
- blank_lz  input  1  1 = blank leading zero digits.
- digit_out  output  4  nibble of current digit, to seg7.in.
- digit_en  output  NUM_DIGITS  active-low digit enables, at most one bit low.
- blank  output  1  1 = current digit blanked; segments must be off.
- frame_start  output  1  one-cycle pulse when scan returns to digit 0.

Behaviour:
- Registers: prescaler cnt, digit index idx, pending register pend plus flag pend_v, displayed register disp.
- Outputs are combinational from registers only. No input-to-output path except blank_lz into blank/digit_en.
- Reset (rst=1 at a clk edge): cnt=0, idx=0, pend=0, pend_v=0, disp=0. Post-reset outputs: digit_out=0, digit_en = all 1s except bit 0 = 0, blank=0, frame_start=0.
- rst dominates load and scanning. Reset mid-frame discards pend and disp, and restarts at digit 0 with cnt=0.
- Prescaler:
  - cnt increments each cycle.
  - When cnt==REFRESH_DIV-1, the next edge sets cnt=0 and idx = (idx==NUM_DIGITS-1) ? 0 : idx+1.
  - Each digit is active exactly REFRESH_DIV cycles. A full frame is NUM_DIGITS*REFRESH_DIV cycles.
- Load:
  - load=1 at an edge sets pend=value_in and pend_v=1.
  - A later load before the frame boundary overwrites pend; last value wins.
- Frame-aligned update:
  - On the edge where idx wraps NUM_DIGITS-1 -> 0, if pend_v then disp=pend and pend_v=0.
  - If load coincides with that wrap edge, the new value goes to pend (pend_v stays 1). disp takes the old pend, and the new value shows next frame.
  - disp never changes mid-frame.
- digit_out = disp[4*idx+3 : 4*idx].
- frame_start = 1 during the first cycle with idx==0 after a wrap, i.e. cnt==0 && idx==0. It is not asserted in the first cycle after reset.
- Leading-zero blanking:
  - Digit i (i>0) is blanked when blank_lz=1 and disp digits i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - When blanked: blank=1 and digit_en = all 1s. digit_out still shows 0.
- Not blanked: blank=0 and digit_en = ~(1<<idx).

Test Plan:
1. Reset then scan (REFRESH_DIV=4, NUM_DIGITS=4): rst 2 cycles, load value_in=16'h1A2F once -> first frame shows 0000. Next frame digit_out sequence F,2,A,1, each held 4 cycles. digit_en sequence 1110, 1101, 1011, 0111. frame_start pulses every 16 cycles.
2. Tear-free update: load 16'h1234 while idx=2 mid-frame -> digits 2 and 3 of the current frame still show the old disp. 1234 appears starting at the next idx=0, exactly on the frame_start cycle.
3. Multiple loads: load 16'hAAAA then 16'h5555 in the same frame -> next frame shows 5555 only. A load coinciding with the wrap edge shows in the following frame.
4. Leading-zero blank: disp=16'h0030, blank_lz=1 -> digit 0 shows 0 enabled, digit 1 shows 3 enabled, digits 2 and 3 have blank=1 and digit_en=1111. With disp=16'h0000, only digit 0 shows 0. With blank_lz=0, all digits are enabled.
5. Reset mid-operation: assert rst at idx=3, cnt=2 with pend_v=1 -> next cycle idx=0, cnt=0, disp=0, pend_v=0. The pending value is never displayed.
6. Chain with seg7: connect digit_out to seg7.in and sweep loads 0..F into digit 0 -> seg7.out matches the seg7 truth table each frame. No enable overlap occurs: at most one digit_en bit is low in any cycle.

Source files
------------

// File: rtl/hex_digit_scanner.sv
// Time-multiplexed scanner for an N-digit common-anode 7-segment display.
// Presents one nibble at a time to the hex decoder with frame-aligned, tear-free value updates.
module hex_digit_scanner #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [3:0]              digit_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    blank,
  output logic                    frame_start
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VAL_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic [VAL_W-1:0] disp_q, disp_d;
  logic             fs_q, fs_d;

  logic             digit_done;
  logic             frame_wrap;

  logic [3:0]       cur_digit;
  logic             upper_zero;
  logic             lz_hit;

  // Prescaler, digit index and the pending/displayed value pipeline
  always_comb begin
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    disp_d   = disp_q;

    digit_done = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    frame_wrap = digit_done && (idx_q == IDX_W'(NUM_DIGITS - 1));

    if (digit_done) begin
      cnt_d = '0;
      idx_d = frame_wrap ? '0 : idx_q + IDX_W'(1);
    end

    // The displayed value only changes as the scan returns to digit 0
    if (frame_wrap && pend_v_q) begin
      disp_d   = pend_q;
      pend_v_d = 1'b0;
    end

    // A load on the wrap edge lands in pend after the old pend moved to disp
    if (load) begin
      pend_d   = value_in;
      pend_v_d = 1'b1;
    end

    fs_d = frame_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      disp_q   <= '0;
      fs_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      disp_q   <= disp_d;
      fs_q     <= fs_d;
    end
  end

  // Current nibble and leading-zero detection, scanning from the top digit down
  always_comb begin
    cur_digit  = 4'h0;
    upper_zero = 1'b1;
    lz_hit     = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (disp_q[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        cur_digit = disp_q[4*i +: 4];
        lz_hit    = upper_zero && (i != 0);
      end
    end
  end

  assign digit_out   = cur_digit;
  assign blank       = blank_lz && lz_hit;
  assign digit_en    = blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
  assign frame_start = fs_q;

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Self-checking bench for hex_digit_scanner: time-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_hex_digit_scanner;

  localparam int unsigned ND    = 4;
  localparam int unsigned RD    = 4;
  localparam int unsigned CW    = 2;
  localparam int unsigned FRAME = ND * RD;

  logic        clk;
  logic        rst;
  logic [15:0] value_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  digit_out;
  logic [3:0]  digit_en;
  logic        blank;
  logic        frame_start;

  int total = 0;
  int bad   = 0;

  // Reference model state: cycles since reset plus the value latches
  int          m_t      = 0;
  logic [15:0] m_disp   = '0;
  logic [15:0] m_pend   = '0;
  logic        m_pend_v = 1'b0;
  bit          m_valid  = 1'b0;

  logic [3:0] t1_dig [4] = '{4'hF, 4'h2, 4'hA, 4'h1};
  logic [3:0] t1_en  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  hex_digit_scanner #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value_in   (value_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .digit_out  (digit_out),
    .digit_en   (digit_en),
    .blank      (blank),
    .frame_start(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (frame_start !== 1'b1 && n < 40);
    chk(name, 32'(frame_start), 32'd1);
  endtask

  // Model: position in the scan follows from elapsed cycles; values swap on frame boundaries
  always @(posedge clk) begin
    if (rst) begin
      m_t      = 0;
      m_disp   = '0;
      m_pend   = '0;
      m_pend_v = 1'b0;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      m_t = m_t + 1;
      if ((m_t % FRAME) == 0 && m_pend_v) begin
        m_disp   = m_pend;
        m_pend_v = 1'b0;
      end
      if (load) begin
        m_pend   = value_in;
        m_pend_v = 1'b1;
      end
    end
  end

  always @(posedge clk) begin : cmp
    int          e_idx;
    logic [3:0]  e_dig;
    logic        e_blank;
    logic [3:0]  e_en;
    logic        e_fs;
    logic [15:0] upper;
    #1;
    if (m_valid) begin
      e_idx   = (m_t / RD) % ND;
      upper   = m_disp >> (4 * e_idx);
      e_dig   = upper[3:0];
      e_blank = blank_lz && (e_idx > 0) && (upper == 16'h0);
      e_en    = e_blank ? 4'hF : ~(4'b0001 << e_idx);
      e_fs    = ((m_t % FRAME) == 0) && (m_t != 0);
      chk("digit_out", 32'(digit_out), 32'(e_dig));
      chk("blank", 32'(blank), 32'(e_blank));
      chk("digit_en", 32'(digit_en), 32'(e_en));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      chk("en_overlap", 32'($countones(~digit_en) <= 1), 32'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    blank_lz = 1'b0;
    value_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_digit_out", 32'(digit_out), 32'h0);
    chk("rst_digit_en", 32'(digit_en), 32'b1110);
    chk("rst_blank", 32'(blank), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    rst = 1'b0;

    // Scan order and hold time
    value_in = 16'h1A2F;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("t1_first_frame_zero", 32'(digit_out), 32'h0);
    wait_frame("t1_sync");
    for (int d = 0; d < 4; d++) begin
      chk("t1_digit", 32'(digit_out), 32'(t1_dig[d]));
      chk("t1_en", 32'(digit_en), 32'(t1_en[d]));
      repeat (4) begin
        @(posedge clk);
        #1;
      end
    end
    chk("t1_period", 32'(frame_start), 32'd1);

    // Mid-frame load must not tear the current frame
    @(negedge clk);
    while (((m_t / RD) % ND) != 2) @(negedge clk);
    value_in = 16'h1234;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("t2_old_digit2", 32'(digit_out), 32'hA);
    wait_frame("t2_sync");
    chk("t2_new_digit0", 32'(digit_out), 32'h4);

    // Last load wins; a load on the wrap edge waits one more frame
    @(negedge clk);
    value_in = 16'hAAAA;
    load     = 1'b1;
    @(negedge clk);
    value_in = 16'h5555;
    @(negedge clk);
    load = 1'b0;
    wait_frame("t3_sync");
    chk("t3_last_wins", 32'(digit_out), 32'h5);
    @(negedge clk);
    value_in = 16'h3333;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    while ((m_t % FRAME) != 15) @(negedge clk);
    value_in = 16'h7777;
    load     = 1'b1;
    @(posedge clk);
    #1;
    chk("t3_wrap_fs", 32'(frame_start), 32'd1);
    chk("t3_old_pend", 32'(digit_out), 32'h3);
    @(negedge clk);
    load = 1'b0;
    wait_frame("t3_sync_b");
    chk("t3_wrap_load", 32'(digit_out), 32'h7);

    // Leading-zero blanking
    blank_lz = 1'b1;
    @(negedge clk);
    value_in = 16'h0030;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_frame("t4_sync");
    chk("t4_d0_digit", 32'(digit_out), 32'h0);
    chk("t4_d0_en", 32'(digit_en), 32'b1110);
    repeat (4) begin @(posedge clk); #1; end
    chk("t4_d1_digit", 32'(digit_out), 32'h3);
    chk("t4_d1_en", 32'(digit_en), 32'b1101);
    chk("t4_d1_blank", 32'(blank), 32'd0);
    repeat (4) begin @(posedge clk); #1; end
    chk("t4_d2_blank", 32'(blank), 32'd1);
    chk("t4_d2_en", 32'(digit_en), 32'b1111);
    chk("t4_d2_digit", 32'(digit_out), 32'h0);
    @(negedge clk);
    value_in = 16'h0000;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_frame("t4_sync_zero");
    chk("t4_zero_d0_en", 32'(digit_en), 32'b1110);
    chk("t4_zero_d0_blank", 32'(blank), 32'd0);
    repeat (4) begin @(posedge clk); #1; end
    chk("t4_zero_d1_en", 32'(digit_en), 32'b1111);
    @(negedge clk);
    blank_lz = 1'b0;
    #1;
    chk("t4_nolz_en", 32'(digit_en), 32'b1101);

    // Reset with a pending value mid-frame
    @(negedge clk);
    value_in = 16'hBEEF;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    while ((m_t % FRAME) != 14) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_rst_en", 32'(digit_en), 32'b1110);
    chk("t5_rst_digit", 32'(digit_out), 32'h0);
    chk("t5_rst_fs", 32'(frame_start), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_frame("t5_sync");
    chk("t5_pend_discarded", 32'(digit_out), 32'h0);

    // Sweep every nibble through digit 0
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      value_in = 16'(v);
      load     = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_frame("t6_sync");
      chk("t6_digit0", 32'(digit_out), 32'(v));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
